// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounced inverse decoder for a multiplexed active-low 7-segment bus
//
// Snoops a multiplexed 7-segment display bus and recovers the hex value shown
// on each digit. The bus tuple {segments, digit enables} is synchronized,
// debounced over STABLE_CYCLES identical samples, and then committed once per
// stable period to the digit whose enable is the single low bit.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_seg          segment drive {g,f,e,d,c,b,a}, 0 = lit
//   i_dig_en       digit enables, active-low, bit i = digit i
//   o_value        decoded nibbles, digit i at [4i+3:4i]
//   o_digit_valid  digit i committed at least once since reset
//   o_digit_blank  last commit of digit i was the blank pattern
//   o_digit_err    last commit of digit i was a non-hex pattern
//   o_frame_valid  1-cycle pulse when every digit has committed since the last pulse

module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [6:0]                i_seg,
    input  logic [NUM_DIGITS-1:0]     i_dig_en,
    output logic [4*NUM_DIGITS-1:0]   o_value,
    output logic [NUM_DIGITS-1:0]     o_digit_valid,
    output logic [NUM_DIGITS-1:0]     o_digit_blank,
    output logic [NUM_DIGITS-1:0]     o_digit_err,
    output logic                      o_frame_valid
);

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Synchronizer stages, the synchronized tuple and its previous sample.
    logic [6:0]              r_seg_m;
    logic [6:0]              r_seg_s;
    logic [6:0]              r_seg_p;
    logic [NUM_DIGITS-1:0]   r_en_m;
    logic [NUM_DIGITS-1:0]   r_en_s;
    logic [NUM_DIGITS-1:0]   r_en_p;

    logic [7:0]              r_cnt;
    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_DIGITS-1:0]   r_seen;

    logic                    w_changed;
    logic [NUM_DIGITS-1:0]   w_low;
    logic                    w_one_zero;
    logic                    w_commit;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic [3:0]              w_nib;
    logic                    w_is_hex;
    logic                    w_is_blank;

    // Idle bus is all-ones, so the synchronizer and previous-sample registers
    // reset to that value and the first real tuple registers as a change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg_m <= '1;
            r_seg_s <= '1;
            r_seg_p <= '1;
            r_en_m  <= '1;
            r_en_s  <= '1;
            r_en_p  <= '1;
        end else begin
            r_seg_m <= i_seg;
            r_seg_s <= r_seg_m;
            r_seg_p <= r_seg_s;
            r_en_m  <= i_dig_en;
            r_en_s  <= r_en_m;
            r_en_p  <= r_en_s;
        end
    end

    assign w_changed = ({r_seg_s, r_en_s} != {r_seg_p, r_en_p});

    // Stability counter, saturating so a long hold cannot wrap back into the
    // commit window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_changed) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Exactly one enable low; blanking (none low) and ghosting (several low)
    // intervals never commit.
    assign w_low      = ~r_en_s;
    assign w_one_zero = (w_low != '0) &&
                        ((w_low & (w_low - NUM_DIGITS'(1))) == '0);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SETTLE: begin
                if (!w_changed && (r_cnt == CNT_LAST) && w_one_zero) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_changed) begin
                    w_state_next = ST_SETTLE;
                end
            end
            default: begin
                w_state_next = ST_SETTLE;
            end
        endcase
    end

    // FSM: output logic
    always_comb begin
        w_commit = 1'b0;
        if (r_state == ST_COMMIT) begin
            w_commit = 1'b1;
        end
    end

    // In COMMIT the previous-sample registers still hold the tuple that was
    // proven stable, even if the live tuple has just moved on.
    assign w_sel       = ~r_en_p;
    assign w_seen_next = r_seen | w_sel;

    // Inverse of the encoder table; anything else is blank or an error.
    always_comb begin
        w_nib      = 4'h0;
        w_is_hex   = 1'b1;
        w_is_blank = 1'b0;
        case (r_seg_p)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h18: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            7'h7F: begin
                w_is_hex   = 1'b0;
                w_is_blank = 1'b1;
            end
            default: begin
                w_is_hex = 1'b0;
            end
        endcase
    end

    // Per-digit result registers; only the selected digit changes on commit,
    // and a non-hex pattern leaves the last good nibble in place.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_value       <= '0;
            o_digit_valid <= '0;
            o_digit_blank <= '0;
            o_digit_err   <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_sel[i]) begin
                    o_digit_valid[i] <= 1'b1;
                    o_digit_blank[i] <= w_is_blank;
                    o_digit_err[i]   <= !w_is_hex && !w_is_blank;
                    if (w_is_hex) begin
                        o_value[4*i +: 4] <= w_nib;
                    end
                end
            end
        end
    end

    // Frame tracking: the commit that completes the seen mask pulses
    // o_frame_valid and starts a fresh frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seen        <= '0;
            o_frame_valid <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            if (w_commit) begin
                if (&w_seen_next) begin
                    r_seen        <= '0;
                    o_frame_valid <= 1'b1;
                end else begin
                    r_seen <= w_seen_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk;
    logic            rst_n;
    logic [6:0]      seg;
    logic [ND-1:0]   dig_en;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   digit_blank;
    logic [ND-1:0]   digit_err;
    logic            frame_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_cnt = 0;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_seg         (seg),
        .i_dig_en      (dig_en),
        .o_value       (value),
        .o_digit_valid (digit_valid),
        .o_digit_blank (digit_blank),
        .o_digit_err   (digit_err),
        .o_frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) frame_cnt++;
    end

    typedef struct {
        logic [6:0] seg;
        int         digit;
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } vec_t;

    vec_t vecs[19];
    logic [6:0] codes[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a tuple on the pins for n sampling edges; returns 1 time unit after the last.
    task automatic apply(input logic [6:0] s, input logic [ND-1:0] e, input int n);
        seg = s;
        dig_en = e;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [ND-1:0] en_of(input int d);
        logic [ND-1:0] e;
        e = '1;
        e[d] = 1'b0;
        return e;
    endfunction

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        apply(s0, en_of(0), 8); apply(s0, 4'b1111, 2);
        apply(s1, en_of(1), 8); apply(s1, 4'b1111, 2);
        apply(s2, en_of(2), 8); apply(s2, 4'b1111, 2);
        apply(s3, en_of(3), 8); apply(s3, 4'b1111, 2);
    endtask

    // Reference model state for the randomized phase.
    logic [3:0] m_val[ND];
    logic [ND-1:0] m_valid, m_blank, m_err, m_seen;
    int m_frames;

    function automatic int zero_index(input logic [ND-1:0] e);
        int cnt, idx;
        cnt = 0;
        idx = -1;
        for (int i = 0; i < ND; i++) begin
            if (!e[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic model_commit(input logic [6:0] s, input int k);
        int hit;
        hit = -1;
        for (int c = 0; c < 16; c++) if (codes[c] == s) hit = c;
        m_valid[k] = 1'b1;
        if (hit >= 0) begin
            m_val[k] = 4'(hit);
            m_blank[k] = 1'b0;
            m_err[k] = 1'b0;
        end else if (s == 7'h7F) begin
            m_blank[k] = 1'b1;
            m_err[k] = 1'b0;
        end else begin
            m_blank[k] = 1'b0;
            m_err[k] = 1'b1;
        end
        m_seen[k] = 1'b1;
        if (m_seen == '1) begin
            m_frames++;
            m_seen = '0;
        end
    endtask

    task automatic gen_tuple(input logic [6:0] ps, input logic [ND-1:0] pe,
                             output logic [6:0] s, output logic [ND-1:0] e);
        do begin
            case ($urandom_range(9))
                0, 1, 2, 3, 4: s = codes[$urandom_range(15)];
                5, 6:          s = 7'h7F;
                default:       s = 7'($urandom);
            endcase
            case ($urandom_range(19))
                0, 1, 2:       e = '1;
                3, 4, 5:       e = ND'($urandom);
                default:       e = en_of($urandom_range(ND - 1));
            endcase
        end while ({s, e} == {ps, pe});
    endtask

    initial begin
        logic [6:0] ps, s;
        logic [ND-1:0] pe, e;
        logic [4*ND-1:0] mv;
        int f0, len, k;

        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 16; i++) vecs[i] = '{codes[i], i % 4, 4'(i), 1'b0, 1'b0};
        vecs[16] = '{7'h7F, 1, 4'hD, 1'b1, 1'b0};
        vecs[17] = '{7'h7E, 3, 4'hF, 1'b0, 1'b1};
        vecs[18] = '{7'h41, 0, 4'hC, 1'b0, 1'b1};

        rst_n = 1'b0;
        seg = 7'h7F;
        dig_en = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_flags", 32'({digit_valid, digit_blank, digit_err, frame_valid}), 32'h0);
        rst_n = 1'b1;

        // 1: single stable digit, latency edge 7
        f0 = frame_cnt;
        apply(7'h24, 4'b1110, 7);
        chk("t1_valid_before_edge7", 32'(digit_valid), 32'h0);
        apply(7'h24, 4'b1110, 1);
        chk("t1_valid_edge7", 32'(digit_valid), 32'h1);
        chk("t1_value_edge7", 32'(value), 32'h0002);
        apply(7'h24, 4'b1110, 2);
        chk("t1_no_frame", 32'(frame_cnt - f0), 32'h0);

        // 2: short glitch never commits
        apply(7'h30, 4'b1101, 3);
        apply(7'h30, 4'b1111, 10);
        chk("t2_value", 32'(value), 32'h0002);
        chk("t2_valid", 32'(digit_valid), 32'h1);
        chk("t2_no_frame", 32'(frame_cnt - f0), 32'h0);

        // 3: full scan, frame pulse on the digit-3 commit edge
        apply(7'h79, en_of(0), 8); apply(7'h79, 4'b1111, 2);
        apply(7'h24, en_of(1), 8); apply(7'h24, 4'b1111, 2);
        apply(7'h30, en_of(2), 8); apply(7'h30, 4'b1111, 2);
        apply(7'h19, en_of(3), 7);
        chk("t3_frame_before", 32'(frame_valid), 32'h0);
        apply(7'h19, en_of(3), 1);
        chk("t3_frame_pulse", 32'(frame_valid), 32'h1);
        chk("t3_value", 32'(value), 32'h4321);
        apply(7'h19, 4'b1111, 1);
        chk("t3_frame_after", 32'(frame_valid), 32'h0);
        apply(7'h19, 4'b1111, 1);
        chk("t3_frame_count", 32'(frame_cnt - f0), 32'h1);

        // 4: invalid pattern then blank on digit 2
        apply(7'h55, 4'b1011, 8);
        chk("t4_err", 32'(digit_err), 32'h4);
        chk("t4_value", 32'(value), 32'h4321);
        apply(7'h7F, 4'b1011, 8);
        chk("t4_blank", 32'(digit_blank), 32'h4);
        chk("t4_err_clear", 32'(digit_err), 32'h0);
        chk("t4_value_kept", 32'(value), 32'h4321);

        // 5: ghosted enables never commit
        f0 = frame_cnt;
        apply(7'h7F, 4'b1111, 2);
        apply(7'h00, 4'b1100, 20);
        chk("t5_value", 32'(value), 32'h4321);
        chk("t5_flags", 32'({digit_valid, digit_blank, digit_err}), 32'hF40);
        chk("t5_no_frame", 32'(frame_cnt - f0), 32'h0);

        // 6: asynchronous reset mid-scan, then a full rescan
        apply(7'h00, 4'b1111, 2);
        apply(7'h79, en_of(0), 8); apply(7'h79, 4'b1111, 2);
        apply(7'h24, en_of(1), 8);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_reset_value", 32'(value), 32'h0);
        chk("t6_reset_flags", 32'({digit_valid, digit_blank, digit_err, frame_valid}), 32'h0);
        @(posedge clk);
        #1;
        seg = 7'h7F;
        dig_en = '1;
        rst_n = 1'b1;
        apply(7'h7F, 4'b1111, 2);
        f0 = frame_cnt;
        scan4(7'h79, 7'h24, 7'h30, 7'h19);
        chk("t6_frame_count", 32'(frame_cnt - f0), 32'h1);
        chk("t6_value", 32'(value), 32'h4321);
        chk("t6_valid", 32'(digit_valid), 32'hF);

        // Table: every code plus blank and invalid patterns
        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].seg, en_of(vecs[i].digit), 8);
            chk($sformatf("tbl%0d_nib", i), 32'(value[4*vecs[i].digit +: 4]), 32'(vecs[i].nib));
            chk($sformatf("tbl%0d_blank", i), 32'(digit_blank[vecs[i].digit]), 32'(vecs[i].blank));
            chk($sformatf("tbl%0d_err", i), 32'(digit_err[vecs[i].digit]), 32'(vecs[i].err));
            apply(vecs[i].seg, 4'b1111, 2);
        end

        // Randomized periods against the reference model
        rst_n = 1'b0;
        seg = 7'h7F;
        dig_en = '1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frame_cnt;
        for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
        m_valid = '0; m_blank = '0; m_err = '0; m_seen = '0; m_frames = 0;
        ps = 7'h7F;
        pe = '1;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(3) == 0) begin
                gen_tuple(ps, pe, s, e);
                apply(s, e, $urandom_range(SC - 1, 1));
                ps = s;
                pe = e;
            end
            gen_tuple(ps, pe, s, e);
            len = $urandom_range(12, 8);
            apply(s, e, len);
            ps = s;
            pe = e;
            k = zero_index(e);
            if (k >= 0) model_commit(s, k);
            for (int d = 0; d < ND; d++) mv[4*d +: 4] = m_val[d];
            chk($sformatf("rnd%0d_value", it), 32'(value), 32'(mv));
            chk($sformatf("rnd%0d_valid", it), 32'(digit_valid), 32'(m_valid));
            chk($sformatf("rnd%0d_blank", it), 32'(digit_blank), 32'(m_blank));
            chk($sformatf("rnd%0d_err", it), 32'(digit_err), 32'(m_err));
            chk($sformatf("rnd%0d_frames", it), 32'(frame_cnt - f0), 32'(m_frames));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
